// File: rtl/cnt_sched_pkg.sv
// Shared types for the round-robin counter scheduler: FSM encodings and a one-hot helper.
// Pure definitions, no latency or flow control of its own.
package cnt_sched_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [MAX_NREQ-1:0] onehot(input logic [2:0] idx);
        onehot = MAX_NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/cnt_sched_if.sv
// Requester-side bundle of the counter scheduler: req/term/abort in, gnt/done/busy/q back.
// Level-held request, no credits; a requester keeps req high until its done pulse.
interface cnt_sched_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] term;
    logic              abort;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      q;

    modport master (output req, term, abort, input gnt, done, busy, q);
    modport slave  (input req, term, abort, output gnt, done, busy, q);
endinterface

// File: rtl/cnt_sched_rr_pick.sv
// Combinational round-robin picker: first set req scanning upward from ptr+1, wrapping.
// Zero latency, no backpressure; valid low when no req is set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cnt_sched.sv
// Shares one W-bit up-counter among NREQ requesters in round-robin order, 0..term then a done pulse.
// Grant one cycle after req in IDLE, RUN lasts term+1 cycles; waiting requesters simply hold req.
module cnt_sched
    import cnt_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    cnt_sched_if.slave   bus
);

    localparam int IW = $clog2(NREQ);

    state_t        state_q, state_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  tlat_q, tlat_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] win_q, win_d;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            tlat_q  <= '0;
            ptr_q   <= IW'(NREQ - 1);
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tlat_q  <= tlat_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tlat_d  = tlat_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        case (state_q)
            ST_RUN: begin
                // A killed count still advances the pointer so the aborted requester loses its turn.
                if (bus.abort || !bus.req[win_q]) begin
                    state_d = ST_IDLE;
                    q_d     = '0;
                    ptr_d   = win_q;
                end else if (q_q == tlat_q) begin
                    state_d = ST_DONE;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = win_q;
            end
            default: begin
                state_d = ST_IDLE;
                if (pick_vld) begin
                    state_d = ST_RUN;
                    win_d   = pick_idx;
                    tlat_d  = bus.term[int'(pick_idx) * W +: W];
                    q_d     = '0;
                end
            end
        endcase
    end

    assign bus.gnt  = (state_q == ST_RUN)  ? NREQ'(onehot(3'(win_q))) : '0;
    assign bus.done = (state_q == ST_DONE) ? NREQ'(onehot(3'(win_q))) : '0;
    assign bus.busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign bus.q    = q_q;

endmodule
